mix_columns_iter: RTL and testbench

- Iterative, clocked AES forward MixColumns engine for the encrypt datapath.
- Counterpart of the combinational inverse_mix_columns used on the decrypt side.
- Accepts one 128-bit state per input handshake and processes COLS_PER_CYCLE columns per clock.
- Returns the result over a valid/ready output handshake. Sits between ShiftRows and AddRoundKey in the encryption round controller.

---
 rtl/mix_columns_iter.sv | 132 +++++++++++++
 tb/tb_mix_columns_iter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_iter
//  Description : Iterative AES forward MixColumns engine. It accepts one
//                128-bit state over a valid/ready handshake, transforms
//                COLS_PER_CYCLE columns per clock and returns the result
//                over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  // Only lane counts that divide the four columns evenly are meaningful.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Multiply by 2 in GF(2^8) with reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column; row 0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    mix_col = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
               a0 ^ x1 ^ x2 ^ a2 ^ a3,
               a0 ^ a1 ^ x2 ^ x3 ^ a3,
               x0 ^ a0 ^ a1 ^ a2 ^ x3};
  endfunction

  state_t       state, state_next;
  logic [1:0]   col;
  logic [127:0] work;
  logic [127:0] work_next;
  logic         accept;
  logic         last;

  logic [6:0]   lane_base [COLS_PER_CYCLE];
  logic [31:0]  lane_in   [COLS_PER_CYCLE];
  logic [31:0]  lane_out  [COLS_PER_CYCLE];

  // One mixer per lane; lane k works on column col+k of the working register.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [1:0] idx;
    assign idx          = col + 2'(k);
    assign lane_base[k] = 7'd127 - {idx, 5'b00000};
    assign lane_in[k]   = work[lane_base[k] -: 32];
    assign lane_out[k]  = mix_col(lane_in[k]);
  end

  // Merge the freshly mixed lanes back into the working state.
  always_comb begin
    work_next = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_next[lane_base[k] -: 32] = lane_out[k];
    end
  end

  assign last      = (col == 2'(4 - COLS_PER_CYCLE));
  assign accept    = in_valid & in_ready;
  assign busy      = (state == COMPUTE);
  assign out_valid = (state == DONE);

  // Next-state and handshake decode; in_ready never depends on in_valid.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? COMPUTE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, column counter, working state and held result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      col      <= 2'd0;
      work     <= 128'd0;
      data_out <= 128'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        work <= data_in;
        col  <= 2'd0;
      end else if (state == COMPUTE) begin
        work <= work_next;
        col  <= col + 2'(COLS_PER_CYCLE);
        if (last) data_out <= work_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_columns_iter
//  Description : Directed self-checking bench for mix_columns_iter with
//                COLS_PER_CYCLE of 1, 2 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_iter;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // Lane-count 1 instance
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_in, data_out;
  // Lane-count 2 instance
  logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [127:0] data_in2, data_out2;
  // Lane-count 4 instance
  logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [127:0] data_in4, data_out4;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy));

  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .data_in(data_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .data_out(data_out2), .busy(busy2));

  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .data_in(data_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .data_out(data_out4), .busy(busy4));

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // General GF(2^8) multiply, used only for the inverse round-trip model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {
        gmul(a0,8'h0E) ^ gmul(a1,8'h0B) ^ gmul(a2,8'h0D) ^ gmul(a3,8'h09),
        gmul(a0,8'h09) ^ gmul(a1,8'h0E) ^ gmul(a2,8'h0B) ^ gmul(a3,8'h0D),
        gmul(a0,8'h0D) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0E) ^ gmul(a3,8'h0B),
        gmul(a0,8'h0B) ^ gmul(a1,8'h0D) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0E)};
    end
    return r;
  endfunction

  // Push one block through the single-lane instance and hand it off.
  task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int n;
    data_in  = din;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd4);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_inverse"}, inv_mix(data_out), din);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_handoff"}, 128'(out_valid), 128'd0);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
  localparam logic [127:0] FIPS_OUT = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] VA_IN    = 128'h0CBEDFEF2D296C0C0ACEAA28C60A2AAE;
  localparam logic [127:0] VA_OUT   = 128'hF1FE3DB041C7C82ADF40F32A0D027136;
  localparam logic [127:0] VB_IN    = 128'hF2C14C5390E9278D50867BACB2F031F8;
  localparam logic [127:0] VB_OUT   = 128'hB8EC5E26B1BDBB64E666CF4EBDE233E7;
  localparam logic [127:0] SW_IN    = {4{32'hD4D4D4D5}};
  localparam logic [127:0] SW_OUT   = {4{32'hD5D5D7D6}};

  initial begin
    int n;
    in_valid  = 1'b0; out_ready  = 1'b0; data_in  = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; data_in2 = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; data_in4 = '0;

    // Reset state
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data_out", data_out, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // FIPS-197 columns: exact latency and busy window
    data_in  = FIPS_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fips_busy_%0d", i), 128'(busy), 128'd1);
      check($sformatf("fips_nvalid_%0d", i), 128'(out_valid), 128'd0);
      tick();
    end
    check("fips_valid", 128'(out_valid), 128'd1);
    check("fips_busy_done", 128'(busy), 128'd0);
    check("fips_data", data_out, FIPS_OUT);

    // Backpressure: output held, inputs ignored
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      data_in  = VA_IN;
      #1;
      check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
      tick();
      check($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'd1);
      check($sformatf("bp_data_%0d", i), data_out, FIPS_OUT);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_idle_ready", 128'(in_ready), 128'd1);
    check("bp_retained", data_out, FIPS_OUT);

    // Round-trip vectors
    run_block("va", VA_IN, VA_OUT);
    run_block("vb", VB_IN, VB_OUT);

    // Back-to-back A then B
    in_valid  = 1'b1;
    out_ready = 1'b1;
    data_in   = VA_IN;
    tick();
    data_in = VB_IN;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("b2b_a_latency", 128'(n), 128'd4);
    check("b2b_a_data", data_out, VA_OUT);
    check("b2b_ready_in_done", 128'(in_ready), 128'd1);
    tick();
    check("b2b_b_accepted", 128'(busy), 128'd1);
    check("b2b_a_consumed", 128'(out_valid), 128'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b2b_busy_%0d", i), 128'(busy), 128'd1);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_b_valid", 128'(out_valid), 128'd1);
    check("b2b_b_data", data_out, VB_OUT);
    tick();
    out_ready = 1'b0;
    check("b2b_idle", 128'(in_ready), 128'd1);

    // Reset mid-COMPUTE aborts the block asynchronously
    data_in  = VA_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 n_rst = 1'b0;
    #1;
    check("arst_valid", 128'(out_valid), 128'd0);
    check("arst_data", data_out, 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("arst_in_ready", 128'(in_ready), 128'd1);
    tick();
    run_block("post_rst", FIPS_IN, FIPS_OUT);

    // Lane-count sweep: 2 lanes
    data_in2  = SW_IN;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      tick();
      n++;
    end
    check("cpc2_latency", 128'(n), 128'd2);
    check("cpc2_data", data_out2, SW_OUT);

    // Lane-count sweep: 4 lanes
    data_in4  = SW_IN;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      tick();
      n++;
    end
    check("cpc4_latency", 128'(n), 128'd1);
    check("cpc4_data", data_out4, SW_OUT);
    check("cpc4_busy_done", 128'(busy4), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
